// File: rtl/sa_skew_feeder.sv
// Operand feeder for the systolic array: captures A/B and replays them as a skewed diagonal wavefront.
// Define FEEDER_B2B_EN to accept a new job during FLUSH, so jobs run with no bubble between them.
module sa_skew_feeder #(
  parameter int N     = 4,
  parameter int WDATA = 4,
  parameter int KW    = $clog2(N + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [KW-1:0]          k_cfg,
  input  logic [N*N*WDATA-1:0]   mat_a,
  input  logic [N*N*WDATA-1:0]   mat_b,
  output logic [N*WDATA-1:0]     matrix_W,
  output logic [N*WDATA-1:0]     matrix_N,
  output logic [KW-1:0]          row_cfg_out,
  output logic [KW-1:0]          col_cfg_out,
  output logic                   busy,
  output logic                   done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = KW + 1;
`ifdef FEEDER_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, FEED, FLUSH} state_t;

  state_t              state_reg, state_next;
  logic [TW-1:0]       t_reg, t_next;
  logic [TW-1:0]       last_beat;
  logic [KW-1:0]       k_reg, k_eff, k_use;
  logic                capture;
  logic                busy_next, done_next;
  logic [N*WDATA-1:0]  w_next, n_next;

  logic [WDATA-1:0]    a_reg [N][N];
  logic [WDATA-1:0]    b_reg [N][N];
  logic [WDATA-1:0]    a_src [N][N];
  logic [WDATA-1:0]    b_src [N][N];

  assign k_eff     = (k_cfg == '0 || k_cfg > KW'(N)) ? KW'(N) : k_cfg;
  assign last_beat = {k_reg, 1'b0} - TW'(2);

  always_comb begin
    state_next = state_reg;
    t_next     = t_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = FEED;
          t_next     = '0;
        end
      end
      FEED: begin
        if (t_reg == last_beat) begin
          state_next = FLUSH;
        end else begin
          t_next = t_reg + TW'(1);
        end
      end
      FLUSH: begin
        if (B2B && start) begin
          capture    = 1'b1;
          state_next = FEED;
          t_next     = '0;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign k_use     = capture ? k_eff : k_reg;
  assign busy_next = (state_next != IDLE);
  assign done_next = (state_reg == FLUSH);

  // On the capture edge the first beat is built straight from the input buses.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      assign a_src[gi][gj] = capture ? mat_a[(gi*N+gj)*WDATA +: WDATA] : a_reg[gi][gj];
      assign b_src[gi][gj] = capture ? mat_b[(gi*N+gj)*WDATA +: WDATA] : b_reg[gi][gj];
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    int               col;
    logic [WDATA-1:0] w_val;
    logic [WDATA-1:0] n_val;
    always_comb begin
      w_val = '0;
      n_val = '0;
      col   = int'(t_next) - gi;
      if (state_next == FEED && gi < int'(k_use) && col >= 0 && col < int'(k_use)) begin
        w_val = a_src[gi][IW'(col)];
        n_val = b_src[IW'(col)][gi];
      end
    end
    assign w_next[gi*WDATA +: WDATA] = w_val;
    assign n_next[gi*WDATA +: WDATA] = n_val;
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      a_reg <= a_src;
      b_reg <= b_src;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      t_reg       <= '0;
      k_reg       <= KW'(N);
      row_cfg_out <= KW'(N);
      col_cfg_out <= KW'(N);
      matrix_W    <= '0;
      matrix_N    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_reg <= state_next;
      t_reg     <= t_next;
      if (capture) begin
        k_reg       <= k_eff;
        row_cfg_out <= k_eff;
        col_cfg_out <= k_eff;
      end
      matrix_W <= w_next;
      matrix_N <= n_next;
      busy     <= busy_next;
      done     <= done_next;
    end
  end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Directed bench for sa_skew_feeder; honours FEEDER_B2B_EN for the back-to-back case.
module tb_sa_skew_feeder;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int KW = $clog2(N + 1);

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [KW-1:0]      k_cfg;
  logic [N*N*W-1:0]   mat_a;
  logic [N*N*W-1:0]   mat_b;
  logic [N*W-1:0]     matrix_W;
  logic [N*W-1:0]     matrix_N;
  logic [KW-1:0]      row_cfg_out;
  logic [KW-1:0]      col_cfg_out;
  logic               busy;
  logic               done;

  logic [N*N*W-1:0]   mat_base;
  int                 n_checks;
  int                 n_fail;

  sa_skew_feeder #(.N(N), .WDATA(W), .KW(KW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .k_cfg       (k_cfg),
    .mat_a       (mat_a),
    .mat_b       (mat_b),
    .matrix_W    (matrix_W),
    .matrix_N    (matrix_N),
    .row_cfg_out (row_cfg_out),
    .col_cfg_out (col_cfg_out),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // West lane i = A[i][t-i], north lane j = B[t-j][j], inside the K x K window.
  function automatic logic [N*W-1:0] exp_w(input logic [N*N*W-1:0] m, input int k, input int t);
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (i < k && t - i >= 0 && t - i < k) r[i*W +: W] = m[(i*N + (t - i))*W +: W];
    return r;
  endfunction

  function automatic logic [N*W-1:0] exp_n(input logic [N*N*W-1:0] m, input int k, input int t);
    logic [N*W-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++)
      if (j < k && t - j >= 0 && t - j < k) r[j*W +: W] = m[((t - j)*N + j)*W +: W];
    return r;
  endfunction

  task automatic check_beat(input string tag, input int k, input int t);
    check_eq({tag, "_w"}, 32'(matrix_W), 32'(exp_w(mat_base, k, t)));
    check_eq({tag, "_n"}, 32'(matrix_N), 32'(exp_n(mat_base, k, t)));
    $display("%s beat %0d: W=%h N=%h busy=%0b", tag, t, matrix_W, matrix_N, busy);
  endtask

  // Cycle c = 1 is the first cycle after the edge that samples start.
  task automatic run_job(input string tag, input int kcfg, input int kexp,
                         input int pulse_at, input bit hand);
    k_cfg = KW'(kcfg);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 2*kexp + 2; c++) begin
      if (c <= 2*kexp - 1) begin
        check_beat(tag, kexp, c - 1);
      end else if (c == 2*kexp) begin
        check_eq({tag, "_flush_w"}, 32'(matrix_W), 32'd0);
        check_eq({tag, "_flush_n"}, 32'(matrix_N), 32'd0);
      end
      check_eq({tag, "_busy"}, 32'(busy), (c <= 2*kexp) ? 32'd1 : 32'd0);
      check_eq({tag, "_done"}, 32'(done), (c == 2*kexp + 1) ? 32'd1 : 32'd0);
      if (c == 2*kexp + 1) begin
        check_eq({tag, "_row_cfg"}, 32'(row_cfg_out), 32'(kexp));
        check_eq({tag, "_col_cfg"}, 32'(col_cfg_out), 32'(kexp));
        $display("%s done at cycle %0d", tag, c);
      end
      if (hand && c == 1) begin
        check_eq({tag, "_hand_b0_w"}, 32'(matrix_W), 32'h0001);
        check_eq({tag, "_hand_b0_n"}, 32'(matrix_N), 32'h0001);
      end
      if (hand && c == 4) begin
        check_eq({tag, "_hand_b3_w"}, 32'(matrix_W), 32'hDA74);
        check_eq({tag, "_hand_b3_n"}, 32'(matrix_N), 32'h47AD);
      end
      if (c == pulse_at) begin
        start = 1'b1;
        mat_a = '1;
      end
      if (c == pulse_at + 1) start = 1'b0;
      @(negedge clk);
    end
    mat_a = mat_base;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        mat_base[(i*N + j)*W +: W] = W'(i*4 + j + 1);
    rst_n = 1'b0;
    start = 1'b0;
    k_cfg = '0;
    mat_a = mat_base;
    mat_b = mat_base;

    repeat (2) @(negedge clk);
    check_eq("rst_w", 32'(matrix_W), 32'd0);
    check_eq("rst_n_lanes", 32'(matrix_N), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_row_cfg", 32'(row_cfg_out), 32'd4);
    check_eq("rst_col_cfg", 32'(col_cfg_out), 32'd4);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_job("full_k4", 4, 4, -1, 1'b1);
    run_job("clamp_k0", 0, 4, -1, 1'b0);
    run_job("clamp_k7", 7, 4, -1, 1'b0);
    run_job("ign_start", 4, 4, 3, 1'b0);
    run_job("reduced_k3", 3, 3, -1, 1'b0);

    // Asynchronous reset between edges during beat 3 of a K=3 job.
    k_cfg = 3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_beat("rstmid", 3, 3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rstmid_w", 32'(matrix_W), 32'd0);
    check_eq("rstmid_n", 32'(matrix_N), 32'd0);
    check_eq("rstmid_busy", 32'(busy), 32'd0);
    check_eq("rstmid_row_cfg", 32'(row_cfg_out), 32'd4);
    check_eq("rstmid_col_cfg", 32'(col_cfg_out), 32'd4);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check_eq("rstmid_no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    run_job("after_rst", 4, 4, -1, 1'b0);

    // Back-to-back: start raised on the FLUSH cycle, second job with K=3.
    k_cfg = 4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 7; t++) begin
      check_beat("b2b_first", 4, t);
      @(negedge clk);
    end
    check_eq("b2b_flush_w", 32'(matrix_W), 32'd0);
    check_eq("b2b_flush_busy", 32'(busy), 32'd1);
    k_cfg = 3;
    start = 1'b1;
    @(negedge clk);
`ifdef FEEDER_B2B_EN
    start = 1'b0;
    check_eq("b2b_done", 32'(done), 32'd1);
    check_eq("b2b_busy_held", 32'(busy), 32'd1);
    check_beat("b2b_second", 3, 0);
`else
    check_eq("b2b_done", 32'(done), 32'd1);
    check_eq("b2b_busy_gap", 32'(busy), 32'd0);
    check_eq("b2b_gap_w", 32'(matrix_W), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check_eq("b2b_second_done", 32'(done), 32'd0);
    check_eq("b2b_second_busy", 32'(busy), 32'd1);
    check_beat("b2b_second", 3, 0);
`endif
    for (int t = 1; t < 5; t++) begin
      @(negedge clk);
      check_beat("b2b_second", 3, t);
      check_eq("b2b_second_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    check_eq("b2b_second_flush_w", 32'(matrix_W), 32'd0);
    check_eq("b2b_second_flush_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("b2b_second_done", 32'(done), 32'd1);
    check_eq("b2b_second_row_cfg", 32'(row_cfg_out), 32'd3);
    check_eq("b2b_second_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
